// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_multi
// Brief   : N_CH independent programmable dividers with toggle and tick
//           outputs, glitch-free divisor staging and a global phase sync.
// Revision: 1.0 - initial release
// ============================================================================
module clk_div_multi #(
    parameter int               N_CH        = 4,
    parameter int               CNT_W       = 32,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(10_000_000),
    parameter int               CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    input  logic             cfg_wr,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    output logic [N_CH-1:0]  clk_div,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  pend
);

    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_zero = '0;

    // A zero divisor is promoted to 1 so div-1 can never wrap.
    logic [CNT_W-1:0] w_wdiv;
    assign w_wdiv = (cfg_div == c_zero) ? c_one : cfg_div;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam logic [CH_W-1:0] c_idx = CH_W'(i);

        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_div;
        logic [CNT_W-1:0] r_nxt;
        logic             r_pend;
        logic             r_clk;
        logic             r_tick;
        logic             w_tc;
        logic             w_wr_hit;
        logic             w_apply;

        assign w_tc     = en[i] && (r_cnt == (r_div - c_one));
        assign w_wr_hit = cfg_wr && (cfg_ch == c_idx);
        // Phase boundaries where a new divisor may take effect without a runt pulse.
        assign w_apply  = sync || w_tc;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt  <= c_zero;
                r_div  <= DEFAULT_DIV;
                r_nxt  <= DEFAULT_DIV;
                r_pend <= 1'b0;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
            end else begin
                if (w_apply) begin
                    if (w_wr_hit) begin
                        r_div  <= w_wdiv;
                        r_pend <= 1'b0;
                    end else if (r_pend) begin
                        r_div  <= r_nxt;
                        r_pend <= 1'b0;
                    end
                end else if (w_wr_hit) begin
                    r_nxt  <= w_wdiv;
                    r_pend <= 1'b1;
                end else if (!en[i] && r_pend) begin
                    r_div  <= r_nxt;
                    r_pend <= 1'b0;
                end

                if (sync || !en[i]) begin
                    r_cnt  <= c_zero;
                    r_clk  <= 1'b0;
                    r_tick <= 1'b0;
                end else if (w_tc) begin
                    r_cnt  <= c_zero;
                    r_clk  <= ~r_clk;
                    r_tick <= 1'b1;
                end else begin
                    r_cnt  <= r_cnt + c_one;
                    r_tick <= 1'b0;
                end
            end
        end

        assign clk_div[i] = r_clk;
        assign tick[i]    = r_tick;
        assign pend[i]    = r_pend;
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_clk_div_multi
// Brief   : Directed self-checking bench for clk_div_multi.
// Revision: 1.0 - initial release
// ============================================================================
module tb_clk_div_multi;

    logic       clk;
    logic       rst;
    logic [3:0] en;
    logic       sync;
    logic       cfg_wr;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [3:0] clk_div;
    logic [3:0] tick;
    logic [3:0] pend;

    // Three-channel instance so an out-of-range channel number is encodable.
    logic [2:0] en3;
    logic       cfg_wr3;
    logic [1:0] cfg_ch3;
    logic [7:0] cfg_div3;
    logic [2:0] clk_div3;
    logic [2:0] tick3;
    logic [2:0] pend3;

    int n_chk;
    int n_fail;

    clk_div_multi #(
        .N_CH        (4),
        .CNT_W       (8),
        .DEFAULT_DIV (8'd5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .cfg_wr  (cfg_wr),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .clk_div (clk_div),
        .tick    (tick),
        .pend    (pend)
    );

    clk_div_multi #(
        .N_CH        (3),
        .CNT_W       (8),
        .DEFAULT_DIV (8'd5)
    ) dut3 (
        .clk     (clk),
        .rst     (rst),
        .en      (en3),
        .sync    (1'b0),
        .cfg_wr  (cfg_wr3),
        .cfg_ch  (cfg_ch3),
        .cfg_div (cfg_div3),
        .clk_div (clk_div3),
        .tick    (tick3),
        .pend    (pend3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        en      = 4'b0000;
        sync    = 1'b0;
        cfg_wr  = 1'b0;
        cfg_ch  = 2'd0;
        cfg_div = 8'd0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en3 = 3'b000; cfg_wr3 = 1'b0; cfg_ch3 = 2'd0; cfg_div3 = 8'd0;
        do_reset();
        rst = 1'b1;
        en  = 4'b1111;
        step();
        n_chk++;
        if ({clk_div, tick, pend} !== 12'h000) begin
            $display("FAIL reset_main: got clk_div=%b tick=%b pend=%b, want all 0", clk_div, tick, pend);
            n_fail++;
        end
        n_chk++;
        if ({clk_div3, tick3, pend3} !== 9'h000) begin
            $display("FAIL reset_3ch: got clk_div=%b tick=%b pend=%b, want all 0", clk_div3, tick3, pend3);
            n_fail++;
        end
        rst = 1'b0;
        en  = 4'b0000;
    endtask

    task automatic test_default_div();
        do_reset();
        en = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            logic [3:0] exp_t;
            logic [3:0] exp_c;
            step();
            exp_t = {3'b000, (k % 5 == 0)};
            exp_c = {3'b000, ((k / 5) % 2 == 1)};
            n_chk++;
            if (tick !== exp_t || clk_div !== exp_c) begin
                $display("FAIL default_div cyc %0d: got tick=%b clk_div=%b, want tick=%b clk_div=%b",
                         k, tick, clk_div, exp_t, exp_c);
                n_fail++;
            end
        end
    endtask

    task automatic test_midcount_write();
        logic [1:8] e_tick = 8'b00010101;
        logic [1:8] e_pend = 8'b01100000;
        logic [1:8] e_clk  = 8'b00011001;
        do_reset();
        cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd4;
        step();
        n_chk++;
        if (pend !== 4'b0010) begin
            $display("FAIL idle_write_pend_set: got pend=%b, want 0010", pend);
            n_fail++;
        end
        cfg_wr = 1'b0;
        step();
        n_chk++;
        if (pend !== 4'b0000) begin
            $display("FAIL idle_write_pend_clr: got pend=%b, want 0000", pend);
            n_fail++;
        end
        en = 4'b0010;
        for (int k = 1; k <= 8; k++) begin
            if (k == 2) begin cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd2; end
            if (k == 3) cfg_wr = 1'b0;
            step();
            n_chk++;
            if (tick[1] !== e_tick[k] || pend[1] !== e_pend[k] || clk_div[1] !== e_clk[k]) begin
                $display("FAIL midcount_write cyc %0d: got tick=%b pend=%b clk=%b, want tick=%b pend=%b clk=%b",
                         k, tick[1], pend[1], clk_div[1], e_tick[k], e_pend[k], e_clk[k]);
                n_fail++;
            end
        end
    endtask

    task automatic test_zero_div();
        logic [1:8] e_tick = 8'b00001111;
        logic [1:8] e_pend = 8'b11110000;
        logic [1:8] e_clk  = 8'b00001010;
        do_reset();
        en = 4'b0100;
        cfg_wr = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd0;
        for (int k = 1; k <= 8; k++) begin
            step();
            cfg_wr = 1'b0;
            n_chk++;
            if (tick[2] !== e_tick[k] || pend[2] !== e_pend[k] || clk_div[2] !== e_clk[k]
                || tick[1:0] !== 2'b00 || tick[3] !== 1'b0) begin
                $display("FAIL zero_div cyc %0d: got tick=%b pend=%b clk_div=%b, want tick[2]=%b pend[2]=%b clk[2]=%b",
                         k, tick, pend, clk_div, e_tick[k], e_pend[k], e_clk[k]);
                n_fail++;
            end
        end
    endtask

    task automatic test_bad_channel();
        en3 = 3'b000;
        cfg_wr3 = 1'b1; cfg_ch3 = 2'd3; cfg_div3 = 8'd2;
        step();
        n_chk++;
        if (pend3 !== 3'b000 || tick3 !== 3'b000 || clk_div3 !== 3'b000) begin
            $display("FAIL bad_channel: got pend=%b tick=%b clk_div=%b, want all 0", pend3, tick3, clk_div3);
            n_fail++;
        end
        cfg_ch3 = 2'd2;
        step();
        n_chk++;
        if (pend3 !== 3'b100) begin
            $display("FAIL valid_channel_3ch: got pend=%b, want 100", pend3);
            n_fail++;
        end
        cfg_wr3 = 1'b0;
        step();
        n_chk++;
        if (pend3 !== 3'b000) begin
            $display("FAIL valid_channel_3ch_clr: got pend=%b, want 000", pend3);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        logic [1:14] e_tick = 14'b00001001001010;
        logic [1:14] e_pend = 14'b01110000000000;
        logic [1:14] e_clk  = 14'b00001110001100;
        do_reset();
        en = 4'b0001;
        cfg_ch = 2'd0;
        for (int k = 1; k <= 14; k++) begin
            case (k)
                2:       begin cfg_wr = 1'b1; cfg_div = 8'd7; end
                3:       begin cfg_wr = 1'b1; cfg_div = 8'd3; end
                11:      begin cfg_wr = 1'b1; cfg_div = 8'd2; end
                default: cfg_wr = 1'b0;
            endcase
            step();
            n_chk++;
            if (tick[0] !== e_tick[k] || pend[0] !== e_pend[k] || clk_div[0] !== e_clk[k]) begin
                $display("FAIL back_to_back cyc %0d: got tick=%b pend=%b clk=%b, want tick=%b pend=%b clk=%b",
                         k, tick[0], pend[0], clk_div[0], e_tick[k], e_pend[k], e_clk[k]);
                n_fail++;
            end
        end
        cfg_wr = 1'b0;
    endtask

    task automatic test_sync();
        logic [3:0] e_tick [1:11] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h4, 4'h8, 4'h3, 4'hC};
        logic [3:0] e_clk  [1:11] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'hC, 4'h4, 4'h7, 4'hB};
        logic [3:0] e_pend [1:11] = '{4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        do_reset();
        for (int k = 1; k <= 11; k++) begin
            cfg_wr = 1'b0;
            sync   = 1'b0;
            case (k)
                1: en = 4'b0001;
                3: en = 4'b1111;
                4: begin cfg_wr = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd3; end
                5: begin cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd2; sync = 1'b1; end
                default: ;
            endcase
            step();
            n_chk++;
            if (tick !== e_tick[k] || clk_div !== e_clk[k] || pend !== e_pend[k]) begin
                $display("FAIL sync cyc %0d: got tick=%b clk_div=%b pend=%b, want tick=%b clk_div=%b pend=%b",
                         k, tick, clk_div, pend, e_tick[k], e_clk[k], e_pend[k]);
                n_fail++;
            end
        end
        cfg_wr = 1'b0;
        sync   = 1'b0;
    endtask

    task automatic test_reset_midop();
        logic [1:6] e_tick = 6'b000010;
        logic [1:6] e_clk  = 6'b000011;
        do_reset();
        en = 4'b0001;
        for (int k = 1; k <= 5; k++) step();
        n_chk++;
        if (tick !== 4'b0001 || clk_div !== 4'b0001) begin
            $display("FAIL midop_pre_tc: got tick=%b clk_div=%b, want 0001 0001", tick, clk_div);
            n_fail++;
        end
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2;
        step();
        n_chk++;
        if (pend !== 4'b0001 || clk_div !== 4'b0001) begin
            $display("FAIL midop_staged: got pend=%b clk_div=%b, want 0001 0001", pend, clk_div);
            n_fail++;
        end
        cfg_wr = 1'b0;
        rst    = 1'b1;
        step();
        n_chk++;
        if ({clk_div, tick, pend} !== 12'h000) begin
            $display("FAIL midop_reset: got clk_div=%b tick=%b pend=%b, want all 0", clk_div, tick, pend);
            n_fail++;
        end
        rst = 1'b0;
        en  = 4'b0001;
        for (int k = 1; k <= 6; k++) begin
            step();
            n_chk++;
            if (tick[0] !== e_tick[k] || clk_div[0] !== e_clk[k]) begin
                $display("FAIL midop_default_restored cyc %0d: got tick=%b clk=%b, want tick=%b clk=%b",
                         k, tick[0], clk_div[0], e_tick[k], e_clk[k]);
                n_fail++;
            end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_bad_channel();
        test_default_div();
        test_midcount_write();
        test_zero_div();
        test_back_to_back();
        test_sync();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
